// File: rtl/maze_pkg.sv
// Shared types and heading lookup helpers for the maze wall-follower.
package maze_pkg;

  typedef enum logic [1:0] {
    N = 2'd0,
    E = 2'd1,
    S = 2'd2,
    W = 2'd3
  } dir_t;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    MOVE    = 3'd1,
    WAIT_MV = 3'd2,
    SETTLE  = 3'd3,
    DECIDE  = 3'd4,
    HDNG    = 3'd5,
    WAIT_HD = 3'd6,
    DONE    = 3'd7
  } state_t;

  localparam logic [11:0] HDNG_N = 12'h000;
  localparam logic [11:0] HDNG_W = 12'h3FF;
  localparam logic [11:0] HDNG_S = 12'h7FF;
  localparam logic [11:0] HDNG_E = 12'hC00;

  // Quarter turn counter-clockwise: N->W->S->E->N
  function automatic dir_t turn_lft(input dir_t d);
    case (d)
      N:       return W;
      W:       return S;
      S:       return E;
      default: return N;
    endcase
  endfunction

  // Quarter turn clockwise: N->E->S->W->N
  function automatic dir_t turn_rght(input dir_t d);
    case (d)
      N:       return E;
      E:       return S;
      S:       return W;
      default: return N;
    endcase
  endfunction

  // About-face: N<->S, E<->W
  function automatic dir_t turn_rev(input dir_t d);
    case (d)
      N:       return S;
      S:       return N;
      E:       return W;
      default: return E;
    endcase
  endfunction

  // Pure table lookup so the 3FF/C00 wrap points never need arithmetic
  function automatic logic [11:0] dir2hdng(input dir_t d);
    case (d)
      N:       return HDNG_N;
      E:       return HDNG_E;
      S:       return HDNG_S;
      default: return HDNG_W;
    endcase
  endfunction

endpackage

// File: rtl/maze_solve.sv
// Wall-follower maze solver: issues forward moves and heading changes to
// the navigate unit, choosing each new heading from the side IR openings.
module maze_solve
  import maze_pkg::*;
#(
  parameter int FAST_SIM   = 1,
  parameter int SETTLE_CYC = 2048
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_md,
  input  logic        cmd0,
  input  logic        lft_opn,
  input  logic        rght_opn,
  input  logic        mv_cmplt,
  input  logic        sol_cmplt,
  output logic        strt_hdng,
  output logic        strt_mv,
  output logic        stp_lft,
  output logic        stp_rght,
  output logic [11:0] dsrd_hdng,
  output logic        solved
);

  // Settle period is shortened for simulation so IR sampling is quick
  localparam int SC = (FAST_SIM != 0) ? 4 : SETTLE_CYC;
  localparam int CW = (SC > 2) ? $clog2(SC) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SC - 1);

  state_t        state;
  state_t        nxt;
  dir_t          dir;
  dir_t          dir_new;
  logic          aff;
  logic [CW-1:0] cnt;
  logic          aff_opn;
  logic          opp_opn;

  // Next state and candidate heading; abort via cmd_md overrides everything
  always_comb begin
    nxt     = state;
    dir_new = dir;
    aff_opn = aff ? lft_opn  : rght_opn;
    opp_opn = aff ? rght_opn : lft_opn;
    if (aff_opn)
      dir_new = aff ? turn_lft(dir) : turn_rght(dir);
    else if (opp_opn)
      dir_new = aff ? turn_rght(dir) : turn_lft(dir);
    else
      dir_new = turn_rev(dir);
    case (state)
      IDLE:    if (!cmd_md) nxt = MOVE;
      MOVE:    nxt = WAIT_MV;
      WAIT_MV: if (mv_cmplt) nxt = SETTLE;
      SETTLE:  if (cnt == CNT_LAST) nxt = DECIDE;
      DECIDE:  nxt = sol_cmplt ? DONE : HDNG;
      HDNG:    nxt = WAIT_HD;
      WAIT_HD: if (mv_cmplt) nxt = MOVE;
      DONE:    nxt = DONE;
      default: nxt = IDLE;
    endcase
    if ((state != IDLE) && cmd_md)
      nxt = IDLE;
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= IDLE;
    else
      state <= nxt;
  end

  // Registered command outputs, heading, affinity and settle counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      strt_mv   <= 1'b0;
      strt_hdng <= 1'b0;
      stp_lft   <= 1'b0;
      stp_rght  <= 1'b0;
      solved    <= 1'b0;
      aff       <= 1'b0;
      dir       <= N;
      dsrd_hdng <= HDNG_N;
      cnt       <= '0;
    end else begin
      // Pulses fire only when the state actually advances (not on abort)
      strt_mv   <= (state == MOVE) && (nxt == WAIT_MV);
      strt_hdng <= (state == HDNG) && (nxt == WAIT_HD);
      solved    <= (nxt == DONE);
      if (state == IDLE) begin
        if (!cmd_md) begin
          aff      <= cmd0;
          stp_lft  <= cmd0;
          stp_rght <= ~cmd0;
        end else begin
          stp_lft  <= 1'b0;
          stp_rght <= 1'b0;
        end
      end
      if ((state == WAIT_MV) && (nxt == SETTLE))
        cnt <= '0;
      else if (state == SETTLE)
        cnt <= cnt + 1'b1;
      // Heading only moves on the DECIDE->HDNG edge, so it is stable in WAIT_HD
      if ((state == DECIDE) && (nxt == HDNG)) begin
        dir       <= dir_new;
        dsrd_hdng <= dir2hdng(dir_new);
      end
    end
  end

endmodule

// File: tb/tb_maze_solve.sv
// Directed bench for maze_solve: affinity latch, turn table, settle timing,
// solve detection, abort and asynchronous reset.
module tb_maze_solve;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_md;
  logic        cmd0;
  logic        lft_opn;
  logic        rght_opn;
  logic        mv_cmplt;
  logic        sol_cmplt;
  logic        strt_hdng;
  logic        strt_mv;
  logic        stp_lft;
  logic        stp_rght;
  logic [11:0] dsrd_hdng;
  logic        solved;

  int n_vec = 0;
  int n_err = 0;
  logic seen;

  maze_solve #(.FAST_SIM(1), .SETTLE_CYC(2048)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_md    (cmd_md),
    .cmd0      (cmd0),
    .lft_opn   (lft_opn),
    .rght_opn  (rght_opn),
    .mv_cmplt  (mv_cmplt),
    .sol_cmplt (sol_cmplt),
    .strt_hdng (strt_hdng),
    .strt_mv   (strt_mv),
    .stp_lft   (stp_lft),
    .stp_rght  (stp_rght),
    .dsrd_hdng (dsrd_hdng),
    .solved    (solved)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Run ticks, flagging any command pulse seen along the way
  task automatic quiet(input int n, input string tag);
    seen = 1'b0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (strt_mv || strt_hdng) seen = 1'b1;
    end
    chk(tag, {11'd0, seen}, 12'd0);
  endtask

  // From WAIT_MV: complete the move, settle, decide, turn, and restart a move
  task automatic step(input logic l, input logic r, input logic [11:0] prev,
                      input logic [11:0] exp, input string tag);
    lft_opn  = l;
    rght_opn = r;
    mv_cmplt = 1'b1;
    tick();
    mv_cmplt = 1'b0;
    repeat (4) tick();
    chk({tag, "_hold"}, dsrd_hdng, prev);
    tick();
    chk(tag, dsrd_hdng, exp);
    chk({tag, "_nohd"}, {11'd0, strt_hdng}, 12'd0);
    tick();
    chk({tag, "_hdpulse"}, {11'd0, strt_hdng}, 12'd1);
    chk({tag, "_nomv"}, {11'd0, strt_mv}, 12'd0);
    mv_cmplt = 1'b1;
    tick();
    mv_cmplt = 1'b0;
    chk({tag, "_hdw1"}, {11'd0, strt_hdng}, 12'd0);
    chk({tag, "_hdstable"}, dsrd_hdng, exp);
    tick();
    chk({tag, "_mvpulse"}, {11'd0, strt_mv}, 12'd1);
    tick();
    chk({tag, "_mvw1"}, {11'd0, strt_mv}, 12'd0);
  endtask

  initial begin
    rst = 1'b1; cmd_md = 1'b1; cmd0 = 1'b0; lft_opn = 1'b0; rght_opn = 1'b0;
    mv_cmplt = 1'b0; sol_cmplt = 1'b0;
    tick(); tick();
    chk("rst_hdng", dsrd_hdng, 12'h000);
    chk("rst_outs", {6'd0, strt_hdng, strt_mv, stp_lft, stp_rght, solved, 1'b0}, 12'd0);
    rst = 1'b0;

    // T1: command mode keeps the solver idle
    quiet(100, "t1_idle_pulses");
    chk("t1_outs", {6'd0, strt_hdng, strt_mv, stp_lft, stp_rght, solved, 1'b0}, 12'd0);
    chk("t1_hdng", dsrd_hdng, 12'h000);

    // T2: start with left affinity
    cmd0 = 1'b1; cmd_md = 1'b0;
    tick();
    chk("t2_stp_lft", {11'd0, stp_lft}, 12'd1);
    chk("t2_stp_rght", {11'd0, stp_rght}, 12'd0);
    chk("t2_mv_early", {11'd0, strt_mv}, 12'd0);
    tick();
    chk("t2_mv_pulse", {11'd0, strt_mv}, 12'd1);
    tick();
    chk("t2_mv_w1", {11'd0, strt_mv}, 12'd0);

    // T3/T4: left affinity turn choices
    step(1'b1, 1'b0, 12'h000, 12'h3FF, "t3_N_lft");
    step(1'b0, 1'b1, 12'h3FF, 12'h000, "t3_W_rght");
    step(1'b0, 1'b0, 12'h000, 12'h7FF, "t4_N_rev");
    step(1'b0, 1'b0, 12'h7FF, 12'h000, "t4_S_rev");

    // Abort in WAIT_MV: back to IDLE, no pulses, heading retained
    cmd_md = 1'b1;
    tick();
    quiet(10, "abort_pulses");
    chk("abort_hdng", dsrd_hdng, 12'h000);

    // T5: restart with right affinity
    cmd0 = 1'b0; cmd_md = 1'b0;
    tick();
    chk("t5_stp_lft", {11'd0, stp_lft}, 12'd0);
    chk("t5_stp_rght", {11'd0, stp_rght}, 12'd1);
    tick();
    chk("t5_mv_pulse", {11'd0, strt_mv}, 12'd1);
    tick();
    step(1'b0, 1'b1, 12'h000, 12'hC00, "t5_N_rght");
    step(1'b1, 1'b0, 12'hC00, 12'h000, "t5_E_lft");
    step(1'b1, 1'b1, 12'h000, 12'hC00, "t5_N_both");
    step(1'b0, 1'b1, 12'hC00, 12'h7FF, "t5_E_rght");

    // T6: sol_cmplt mid-move has no effect until the move completes
    sol_cmplt = 1'b1;
    quiet(6, "t6_midmove_pulses");
    chk("t6_midmove_solved", {11'd0, solved}, 12'd0);
    mv_cmplt = 1'b1;
    tick();
    mv_cmplt = 1'b0;
    repeat (4) tick();
    chk("t6_decide_solved", {11'd0, solved}, 12'd0);
    tick();
    chk("t6_solved", {11'd0, solved}, 12'd1);
    chk("t6_hdng", dsrd_hdng, 12'h7FF);
    quiet(5, "t6_done_pulses");
    chk("t6_solved_hold", {11'd0, solved}, 12'd1);
    sol_cmplt = 1'b0;
    cmd_md = 1'b1;
    tick();
    chk("t6_solved_clr", {11'd0, solved}, 12'd0);

    // mv_cmplt coincident with abort: abort wins
    cmd0 = 1'b1; cmd_md = 1'b0;
    tick(); tick(); tick();
    lft_opn = 1'b1;
    mv_cmplt = 1'b1; cmd_md = 1'b1;
    tick();
    mv_cmplt = 1'b0;
    quiet(10, "coinc_pulses");
    chk("coinc_hdng", dsrd_hdng, 12'h7FF);

    // Asynchronous reset mid-operation returns heading to N immediately
    cmd_md = 1'b0;
    tick();
    chk("prerst_stp_lft", {11'd0, stp_lft}, 12'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst_hdng", dsrd_hdng, 12'h000);
    chk("arst_stp", {10'd0, stp_lft, stp_rght}, 12'd0);
    tick();
    rst = 1'b0;
    cmd_md = 1'b1;
    tick();
    chk("arst_mv", {11'd0, strt_mv}, 12'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
